// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between write-back and a 2-deep debug FIFO.
// Optional WB_ARB_R0_GUARD_EN suppresses the write enable for destination register 0.
module wb_write_arbiter #(
    parameter int LEN = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [LEN-1:0]                  i_wb_write_data,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_wb_write_reg,
    input  logic                            i_wb_RegWrite,
    input  logic                            i_dbg_valid,
    input  logic [LEN-1:0]                  i_dbg_data,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_dbg_reg,
    output logic                            o_dbg_ready,
    output logic [LEN-1:0]                  o_write_data,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic                            o_RegWrite,
    output logic                            o_stall
);
    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t                          state, state_next;
    logic [LEN-1:0]                  fifo_data [2];
    logic [NB_ADDRESS_REGISTROS-1:0] fifo_reg  [2];
    logic [1:0]                      count, count_next;
    logic [3:0]                      wait_cnt, wait_next;
    logic                            push, pop, grant_wb, grant, reg_we;
    logic [LEN-1:0]                  grant_data;
    logic [NB_ADDRESS_REGISTROS-1:0] grant_reg;

    assign o_dbg_ready = count != 2'd2;
    assign push        = i_dbg_valid && o_dbg_ready;

    always_comb begin
        pop        = state != IDLE && (state == FORCE || !i_wb_RegWrite);
        grant_wb   = state != FORCE && i_wb_RegWrite;
        grant      = pop || grant_wb;
        grant_data = pop ? fifo_data[0] : i_wb_write_data;
        grant_reg  = pop ? fifo_reg[0] : i_wb_write_reg;
        count_next = count + {1'b0, push} - {1'b0, pop};
        wait_next  = pop ? 4'd0 : (grant_wb && state != IDLE) ? wait_cnt + 4'd1 : wait_cnt;
        // an entry pushed while the last one pops keeps the FSM out of IDLE
        state_next = count_next == 2'd0 ? IDLE : wait_next >= MAX_W ? FORCE : PEND;
    end

`ifdef WB_ARB_R0_GUARD_EN
    assign reg_we = grant && grant_reg != '0;
`else
    assign reg_we = grant;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            count        <= 2'd0;
            wait_cnt     <= 4'd0;
            o_write_data <= '0;
            o_write_reg  <= '0;
            o_RegWrite   <= 1'b0;
            o_stall      <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            wait_cnt   <= wait_next;
            o_RegWrite <= reg_we;
            o_stall    <= state_next == FORCE;
            if (grant) begin
                o_write_data <= grant_data;
                o_write_reg  <= grant_reg;
            end
        end
    end

    // storage needs no reset: clearing count discards every entry
    always_ff @(posedge i_clk) begin
        if (pop) begin
            fifo_data[0] <= fifo_data[1];
            fifo_reg[0]  <= fifo_reg[1];
        end
        if (push) begin
            if (count == 2'd1 && !pop) begin
                fifo_data[1] <= i_dbg_data;
                fifo_reg[1]  <= i_dbg_reg;
            end else begin
                fifo_data[0] <= i_dbg_data;
                fifo_reg[0]  <= i_dbg_reg;
            end
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int MAX_WAIT = 4;

    logic        i_clk = 1'b0, i_reset = 1'b0;
    logic [31:0] i_wb_write_data = '0, i_dbg_data = '0;
    logic [4:0]  i_wb_write_reg = '0, i_dbg_reg = '0;
    logic        i_wb_RegWrite = 1'b0, i_dbg_valid = 1'b0;
    logic        o_dbg_ready, o_RegWrite, o_stall;
    logic [31:0] o_write_data;
    logic [4:0]  o_write_reg;

    int checks = 0, failures = 0;

    logic [31:0] q_data [$];
    logic [4:0]  q_reg  [$];
    int          age;
    logic        forced, exp_we, exp_stall;
    logic [31:0] exp_data;
    logic [4:0]  exp_reg;

    always #5 i_clk = ~i_clk;

    wb_write_arbiter #(.LEN(32), .NB_ADDRESS_REGISTROS(5), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_write_data(i_wb_write_data), .i_wb_write_reg(i_wb_write_reg), .i_wb_RegWrite(i_wb_RegWrite),
        .i_dbg_valid(i_dbg_valid), .i_dbg_data(i_dbg_data), .i_dbg_reg(i_dbg_reg),
        .o_dbg_ready(o_dbg_ready), .o_write_data(o_write_data), .o_write_reg(o_write_reg),
        .o_RegWrite(o_RegWrite), .o_stall(o_stall)
    );

    function automatic logic guard_we(input logic [4:0] r);
`ifdef WB_ARB_R0_GUARD_EN
        return r != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic wb, input logic [4:0] wr, input logic [31:0] wd,
                         input logic dv, input logic [4:0] dr, input logic [31:0] dd);
        i_wb_RegWrite = wb; i_wb_write_reg = wr; i_wb_write_data = wd;
        i_dbg_valid = dv; i_dbg_reg = dr; i_dbg_data = dd;
    endtask

    task automatic apply_reset;
        i_reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        q_data.delete(); q_reg.delete();
        age = 0; forced = 0; exp_we = 0; exp_stall = 0; exp_data = '0; exp_reg = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    task automatic test_reset;
        i_reset = 1'b0;
        drive(1, 5, 32'h1234, 1, 6, 32'h5678);
        repeat (2) tick;
        checks += 5;
        if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", o_RegWrite); end
        if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
        if (o_write_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_write_data); end
        if (o_write_reg !== 5'd0) begin failures++; $display("FAIL reset_reg got=%0d exp=0", o_write_reg); end
        if (o_dbg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_dbg_ready); end
    endtask

    task automatic test_wb_write;
        apply_reset;
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        checks += 4;
        if (o_RegWrite !== 1'b1) begin failures++; $display("FAIL wb_we got=%b exp=1", o_RegWrite); end
        if (o_write_reg !== 5'd5) begin failures++; $display("FAIL wb_reg got=%0d exp=5", o_write_reg); end
        if (o_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wb_data got=%h exp=deadbeef", o_write_data); end
        if (o_stall !== 1'b0) begin failures++; $display("FAIL wb_stall got=%b exp=0", o_stall); end
        tick;
        checks += 2;
        if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL idle_we got=%b exp=0", o_RegWrite); end
        if (o_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL idle_hold got=%h exp=deadbeef", o_write_data); end
    endtask

    task automatic test_dbg_write;
        apply_reset;
        drive(0, 0, 0, 1, 3, 32'h11);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        checks += 2;
        if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL dbg_early_we got=%b exp=0", o_RegWrite); end
        if (o_dbg_ready !== 1'b1) begin failures++; $display("FAIL dbg_ready1 got=%b exp=1", o_dbg_ready); end
        tick;
        checks += 4;
        if (o_RegWrite !== 1'b1) begin failures++; $display("FAIL dbg_we got=%b exp=1", o_RegWrite); end
        if (o_write_reg !== 5'd3) begin failures++; $display("FAIL dbg_reg got=%0d exp=3", o_write_reg); end
        if (o_write_data !== 32'h11) begin failures++; $display("FAIL dbg_data got=%h exp=11", o_write_data); end
        if (o_dbg_ready !== 1'b1) begin failures++; $display("FAIL dbg_ready2 got=%b exp=1", o_dbg_ready); end
    endtask

    task automatic test_force;
        apply_reset;
        drive(1, 7, 32'h100, 1, 9, 32'h55);
        tick;
        checks += 2;
        if (o_RegWrite !== 1'b1 || o_write_data !== 32'h100) begin failures++; $display("FAIL force_push_cycle got=%b/%h exp=1/100", o_RegWrite, o_write_data); end
        if (o_stall !== 1'b0) begin failures++; $display("FAIL force_stall0 got=%b exp=0", o_stall); end
        for (int i = 1; i <= MAX_WAIT; i++) begin
            drive(1, 7, 32'h100 + i, 0, 0, 0);
            tick;
            checks += 2;
            if (o_RegWrite !== 1'b1 || o_write_reg !== 5'd7 || o_write_data !== 32'h100 + i) begin
                failures++; $display("FAIL force_wb%0d got=%b/%0d/%h exp=1/7/%h", i, o_RegWrite, o_write_reg, o_write_data, 32'h100 + i);
            end
            if (o_stall !== (i == MAX_WAIT)) begin failures++; $display("FAIL force_stall%0d got=%b exp=%b", i, o_stall, i == MAX_WAIT); end
        end
        drive(1, 7, 32'h105, 0, 0, 0);
        tick;
        checks += 2;
        if (o_RegWrite !== 1'b1 || o_write_reg !== 5'd9 || o_write_data !== 32'h55) begin
            failures++; $display("FAIL force_dbg got=%b/%0d/%h exp=1/9/55", o_RegWrite, o_write_reg, o_write_data);
        end
        if (o_stall !== 1'b0) begin failures++; $display("FAIL force_stall_end got=%b exp=0", o_stall); end
        tick;
        checks++;
        if (o_RegWrite !== 1'b1 || o_write_reg !== 5'd7 || o_write_data !== 32'h105) begin
            failures++; $display("FAIL force_resume got=%b/%0d/%h exp=1/7/105", o_RegWrite, o_write_reg, o_write_data);
        end
    endtask

    task automatic test_fifo_full;
        logic [31:0] got [$];
        int cyc = 0, seen_at_accept = -1;
        logic acc;
        apply_reset;
        drive(1, 1, 0, 1, 10, 32'hA0);
        tick;
        checks++;
        if (o_dbg_ready !== 1'b1) begin failures++; $display("FAIL full_ready1 got=%b exp=1", o_dbg_ready); end
        drive(1, 1, 0, 1, 11, 32'hA1);
        tick;
        checks++;
        if (o_dbg_ready !== 1'b0) begin failures++; $display("FAIL full_ready2 got=%b exp=0", o_dbg_ready); end
        drive(1, 1, 0, 1, 12, 32'hA2);
        while (got.size() < 3 && cyc < 60) begin
            acc = i_dbg_valid && o_dbg_ready;
            if (acc) seen_at_accept = got.size();
            tick;
            cyc++;
            if (acc) i_dbg_valid = 1'b0;
            if (o_RegWrite && o_write_reg >= 5'd10) got.push_back(o_write_data);
        end
        drive(0, 0, 0, 0, 0, 0);
        checks += 3;
        if (seen_at_accept != 1) begin failures++; $display("FAIL full_accept got=%0d exp=1 pops before third push", seen_at_accept); end
        if (got.size() != 3) begin failures++; $display("FAIL full_count got=%0d exp=3", got.size()); end
        else if (got[0] !== 32'hA0 || got[1] !== 32'hA1 || got[2] !== 32'hA2) begin
            failures++; $display("FAIL full_order got=%h,%h,%h exp=a0,a1,a2", got[0], got[1], got[2]);
        end
    endtask

    task automatic test_r0;
        logic exp;
        apply_reset;
        exp = guard_we(5'd0);
        drive(0, 0, 0, 1, 0, 32'h77);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        checks += 2;
        if (o_RegWrite !== exp) begin failures++; $display("FAIL r0_we got=%b exp=%b", o_RegWrite, exp); end
        if (o_write_reg !== 5'd0) begin failures++; $display("FAIL r0_reg got=%0d exp=0", o_write_reg); end
        tick;
        checks += 2;
        if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL r0_popped got=%b exp=0", o_RegWrite); end
        if (o_dbg_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", o_dbg_ready); end
    endtask

    task automatic test_reset_pending;
        int bad = 0;
        apply_reset;
        drive(1, 2, 0, 1, 20, 32'hB0);
        tick;
        drive(1, 2, 0, 1, 21, 32'hB1);
        tick;
        drive(1, 2, 0, 0, 0, 0);
        repeat (3) tick;
        checks++;
        if (o_stall !== 1'b1) begin failures++; $display("FAIL rp_in_force got=%b exp=1", o_stall); end
        #2 i_reset = 1'b0;
        #1;
        checks += 3;
        if (o_stall !== 1'b0) begin failures++; $display("FAIL rp_async_stall got=%b exp=0", o_stall); end
        if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL rp_async_we got=%b exp=0", o_RegWrite); end
        if (o_dbg_ready !== 1'b1) begin failures++; $display("FAIL rp_async_ready got=%b exp=1", o_dbg_ready); end
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (12) begin
            tick;
            if (o_RegWrite !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rp_no_write got=%0d writes exp=0", bad); end
    endtask

    task automatic test_random;
        logic wb, dv, push, pop, gwb;
        logic [4:0] wr, dr;
        logic [31:0] wd, dd;
        apply_reset;
        for (int n = 0; n < 600; n++) begin
            wb = ($urandom % 4) != 0;
            dv = ($urandom % 3) == 0;
            wr = 5'($urandom); dr = 5'($urandom);
            wd = $urandom; dd = $urandom;
            drive(wb, wr, wd, dv, dr, dd);
            checks++;
            if (o_dbg_ready !== (q_data.size() < 2)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, o_dbg_ready, q_data.size() < 2); end
            push = dv && q_data.size() < 2;
            pop  = q_data.size() > 0 && (forced || !wb);
            gwb  = !forced && wb;
            if (pop) begin
                exp_we = guard_we(q_reg[0]); exp_reg = q_reg[0]; exp_data = q_data[0];
                void'(q_reg.pop_front()); void'(q_data.pop_front());
                age = 0;
            end else if (gwb) begin
                exp_we = guard_we(wr); exp_reg = wr; exp_data = wd;
                if (q_data.size() > 0) age++;
            end else exp_we = 1'b0;
            if (push) begin q_data.push_back(dd); q_reg.push_back(dr); end
            forced = q_data.size() > 0 && age >= MAX_WAIT;
            exp_stall = forced;
            tick;
            checks += 4;
            if (o_RegWrite !== exp_we) begin failures++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", n, o_RegWrite, exp_we); end
            if (o_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", n, o_stall, exp_stall); end
            if (o_write_reg !== exp_reg) begin failures++; $display("FAIL rnd_reg cyc=%0d got=%0d exp=%0d", n, o_write_reg, exp_reg); end
            if (o_write_data !== exp_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, o_write_data, exp_data); end
        end
    endtask

    initial begin
        test_reset;
        test_wb_write;
        test_dbg_write;
        test_force;
        test_fifo_full;
        test_r0;
        test_reset_pending;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- LEN, 32, data width
- NB_ADDRESS_REGISTROS, 5, register address width
- MAX_WAIT, 4, max cycles the debug head entry may be deferred (range 1..15)

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- i_clk, in, 1, single clock, rising edge
- i_reset, in, 1, asynchronous active-low reset
- i_wb_write_data, in, LEN, write-back stage data
- i_wb_write_reg, in, NB_ADDRESS_REGISTROS, write-back destination
- i_wb_RegWrite, in, 1, write-back write request
- i_dbg_valid, in, 1, debug-unit write request
- i_dbg_data, in, LEN, debug write data
- i_dbg_reg, in, NB_ADDRESS_REGISTROS, debug destination
- o_dbg_ready, out, 1, debug FIFO can accept
- o_write_data, out, LEN, register-file write data
- o_write_reg, out, NB_ADDRESS_REGISTROS, register-file write address
- o_RegWrite, out, 1, register-file write enable
- o_stall, out, 1, pipeline freeze request

Function
REQ-003 SHALL share the single register-file write port between the write-back stage and the debug unit.
REQ-004 SHALL buffer debug requests in a 2-entry FIFO; push occurs when i_dbg_valid and o_dbg_ready are both 1.
REQ-005 o_dbg_ready SHALL be 1 exactly when the FIFO count is below 2; simultaneous push and pop SHALL leave the count unchanged.
REQ-006 SHALL register o_write_data, o_write_reg and o_RegWrite, with 1-cycle latency from the grant decision to the port.
REQ-007 SHALL implement a 3-state FSM:
- IDLE: FIFO empty
- PEND: FIFO non-empty, wait counter below MAX_WAIT
- FORCE: debug head must be served

REQ-008 In IDLE and PEND, when i_wb_RegWrite=1, the arbiter SHALL grant the write-back stage; if the FIFO is non-empty, the wait counter SHALL increment.
REQ-009 In IDLE and PEND, when i_wb_RegWrite=0 and the FIFO is non-empty, the arbiter SHALL grant and pop the FIFO head and clear the wait counter.
REQ-010 PEND SHALL go to FORCE when the wait counter reaches MAX_WAIT.
- o_stall SHALL be registered: 1 for exactly the one cycle spent in FORCE.

REQ-011 In FORCE, the arbiter SHALL ignore i_wb_* (the pipeline holds its write-back inputs), grant and pop the FIFO head, and clear the wait counter.
- Next state: PEND if entries remain, else IDLE.

REQ-012 A FIFO entry pushed in the same cycle as the FIFO empties SHALL be kept; the FSM SHALL move to PEND, not IDLE.
REQ-013 When neither source is granted, o_RegWrite SHALL be 0 and o_write_data/o_write_reg SHALL hold their previous values.
REQ-014 When both sources target the same register in the same cycle, the write-back write SHALL commit first and the debug write later; the last writer wins.

Reset
REQ-015 While i_reset=0, the block SHALL clear the FIFO, wait counter and FSM (state IDLE).
- o_write_data=0, o_write_reg=0, o_RegWrite=0, o_stall=0, o_dbg_ready=1.

REQ-016 Reset asserted mid-FORCE or with entries pending SHALL discard all pending debug writes; no write SHALL issue after reset releases.

Configuration
REQ-017 Macro WB_ARB_R0_GUARD_EN:
- When defined, any grant with destination register 0 SHALL still pop or consume the request but drive o_RegWrite=0.
- When undefined, register-0 writes SHALL pass through unchanged.

Verification
REQ-018 Reset, then i_wb_RegWrite=1, reg=5, data=0xDEADBEEF -> next cycle o_RegWrite=1, o_write_reg=5, o_write_data=0xDEADBEEF, o_stall=0.
REQ-019 i_wb_RegWrite=0, debug push reg=3, data=0x11 -> debug write appears on the port 2 cycles after the push; o_dbg_ready stays 1.
REQ-020 i_wb_RegWrite=1 every cycle, one debug push, MAX_WAIT=4 -> 4 write-back writes, then o_stall=1 for 1 cycle with the debug write issued, then write-back resumes.
REQ-021 Three back-to-back debug pushes while i_wb_RegWrite=1 -> o_dbg_ready=0 after the second push; the third is accepted only after a pop; no entry is lost.
REQ-022 Debug push reg=0 with WB_ARB_R0_GUARD_EN defined -> FIFO pops, o_RegWrite stays 0; with the macro undefined -> o_RegWrite=1, o_write_reg=0.
